sbox5_serial_decoder: RTL and testbench



---
 rtl/sbox5_serial_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_sbox5_serial_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox5_serial_decoder.sv
// Serial receiver for framed 5-bit symbols (start 0, 5 data LSB first, stop 1)
// that undoes the 5-bit S-box scrambler, behind the TinyTapeout 8-in/8-out pin wrapper.
module sbox5_serial_decoder #(
    parameter int BIT_CYCLES = 1
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int H  = (BIT_CYCLES - 1) / 2;
    localparam int TW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] T_BIT  = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] T_HALF = TW'((H > 0) ? (H - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    logic w_clk;
    logic w_rst_n;
    logic w_sin;
    logic w_bypass;
    logic w_unused;

    assign w_clk    = io_in[0];
    assign w_rst_n  = io_in[1];
    assign w_sin    = io_in[2];
    assign w_bypass = io_in[3];
    assign w_unused = ^io_in[7:4];

    // Inverse S-box G: maps a scrambled symbol y back to the original x.
    function automatic logic [4:0] g_inv(input logic [4:0] y);
        case (y)
            5'd0:    g_inv = 5'd5;
            5'd1:    g_inv = 5'd3;
            5'd2:    g_inv = 5'd10;
            5'd3:    g_inv = 5'd29;
            5'd4:    g_inv = 5'd0;
            5'd5:    g_inv = 5'd24;
            5'd6:    g_inv = 5'd19;
            5'd7:    g_inv = 5'd30;
            5'd8:    g_inv = 5'd28;
            5'd9:    g_inv = 5'd26;
            5'd10:   g_inv = 5'd23;
            5'd11:   g_inv = 5'd4;
            5'd12:   g_inv = 5'd14;
            5'd13:   g_inv = 5'd7;
            5'd14:   g_inv = 5'd25;
            5'd15:   g_inv = 5'd1;
            5'd16:   g_inv = 5'd11;
            5'd17:   g_inv = 5'd13;
            5'd18:   g_inv = 5'd12;
            5'd19:   g_inv = 5'd27;
            5'd20:   g_inv = 5'd18;
            5'd21:   g_inv = 5'd20;
            5'd22:   g_inv = 5'd21;
            5'd23:   g_inv = 5'd6;
            5'd24:   g_inv = 5'd22;
            5'd25:   g_inv = 5'd17;
            5'd26:   g_inv = 5'd16;
            5'd27:   g_inv = 5'd2;
            5'd28:   g_inv = 5'd9;
            5'd29:   g_inv = 5'd31;
            5'd30:   g_inv = 5'd15;
            5'd31:   g_inv = 5'd8;
            default: g_inv = 5'd0;
        endcase
    endfunction

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit;
    logic [4:0]    r_shift;
    logic [4:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_busy;

    state_t        w_state_nx;
    logic [TW-1:0] w_timer_nx;
    logic [2:0]    w_bit_nx;
    logic [4:0]    w_shift_nx;
    logic [4:0]    w_data_nx;
    logic          w_valid_nx;
    logic          w_ferr_nx;
    logic          w_s;
    logic          w_tick;

    assign w_s    = r_sync2;
    assign w_tick = (r_timer == TW'(0));

    // Next-state and output logic for the frame receiver.
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_data_nx  = r_data;
        w_valid_nx = 1'b0;
        w_ferr_nx  = r_ferr;
        case (r_state)
            ST_IDLE: begin
                if (!w_s) begin
                    w_bit_nx = 3'd0;
                    // With H == 0 the start-bit re-check falls on the detection edge itself.
                    if (H == 0) begin
                        w_state_nx = ST_DATA;
                        w_timer_nx = T_BIT;
                    end else begin
                        w_state_nx = ST_START;
                        w_timer_nx = T_HALF;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (w_s) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_DATA;
                        w_timer_nx = T_BIT;
                        w_bit_nx   = 3'd0;
                    end
                end else begin
                    w_timer_nx = r_timer - TW'(1);
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    // LSB arrives first, so shifting right leaves bit k at position k.
                    w_shift_nx = {w_s, r_shift[4:1]};
                    w_timer_nx = T_BIT;
                    if (r_bit == 3'd4) begin
                        w_state_nx = ST_STOP;
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end else begin
                    w_timer_nx = r_timer - TW'(1);
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (w_s) begin
                        w_data_nx  = w_bypass ? r_shift : g_inv(r_shift);
                        w_valid_nx = 1'b1;
                        w_ferr_nx  = 1'b0;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = ST_WAIT_HIGH;
                    end
                end else begin
                    w_timer_nx = r_timer - TW'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (w_s) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_WAIT_HIGH;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State, synchroniser and registered output flops.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= ST_IDLE;
            r_timer <= TW'(0);
            r_bit   <= 3'd0;
            r_shift <= 5'd0;
            r_data  <= 5'd0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= w_sin;
            r_sync2 <= r_sync1;
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_ferr  <= w_ferr_nx;
            r_busy  <= (w_state_nx != ST_IDLE);
        end
    end

    assign io_out = {r_busy, r_ferr, r_valid, r_data};

endmodule

// File: tb/tb_sbox5_serial_decoder.sv
// Randomised self-checking bench: two decoder instances (1 and 4 clocks per bit)
// compared against a frame-level reference model built from the G table.
module tb_sbox5_serial_decoder;

    localparam int BC_A = 1;
    localparam int BC_B = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin_a = 1'b1;
    logic       sin_b = 1'b1;
    logic       byp_a = 1'b0;
    logic       byp_b = 1'b0;
    logic [3:0] junk  = 4'd0;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] out_a;
    logic [7:0] out_b;

    assign in_a = {junk, byp_a, sin_a, rst_n, clk};
    assign in_b = {~junk, byp_b, sin_b, rst_n, clk};

    sbox5_serial_decoder #(.BIT_CYCLES(BC_A)) u_dut_a (.io_in(in_a), .io_out(out_a));
    sbox5_serial_decoder #(.BIT_CYCLES(BC_B)) u_dut_b (.io_in(in_b), .io_out(out_b));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: G table, derived F table, expected pulses and sticky state.
    int         g_tab[32] = '{5, 3, 10, 29, 0, 24, 19, 30, 28, 26, 23, 4, 14, 7, 25, 1,
                              11, 13, 12, 27, 18, 20, 21, 6, 22, 17, 16, 2, 9, 31, 15, 8};
    int         f_tab[32];
    int         exp_a[$];
    int         exp_b[$];
    logic [4:0] last_a = 5'd0;
    logic [4:0] last_b = 5'd0;
    logic       ferr_a = 1'b0;
    logic       ferr_b = 1'b0;

    int   cyc = 0;
    logic pv_a = 1'b0;
    logic pv_b = 1'b0;
    int   got_a[$];
    int   got_b[$];
    int   cyc_a[$];

    // Valid-pulse monitor: records every decoded symbol and rejects back-to-back strobes.
    always @(negedge clk) begin
        cyc++;
        if (out_a[5]) begin
            check_eq("a_valid_single", {31'd0, pv_a}, 32'd0);
            got_a.push_back(int'(out_a[4:0]));
            cyc_a.push_back(cyc);
        end
        if (out_b[5]) begin
            check_eq("b_valid_single", {31'd0, pv_b}, 32'd0);
            got_b.push_back(int'(out_b[4:0]));
        end
        pv_a = out_a[5];
        pv_b = out_b[5];
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) sin_b = v;
        else     sin_a = v;
    endtask

    task automatic send(input bit sel, input logic [4:0] sym, input logic stop, input int nbits);
        logic [6:0] fr;
        int         bc;
        fr   = {stop, sym, 1'b0};
        bc   = sel ? BC_B : BC_A;
        junk = 4'($urandom);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, fr[i]);
            repeat (bc) @(negedge clk);
        end
    endtask

    task automatic frame(input bit sel, input logic [4:0] sym, input logic stop);
        logic [4:0] e;
        logic       byp;
        byp = sel ? byp_b : byp_a;
        e   = byp ? sym : 5'(g_tab[sym]);
        send(sel, sym, stop, 7);
        if (stop) begin
            if (sel) begin exp_b.push_back(int'(e)); last_b = e; ferr_b = 1'b0; end
            else     begin exp_a.push_back(int'(e)); last_a = e; ferr_a = 1'b0; end
        end else begin
            if (sel) ferr_b = 1'b1;
            else     ferr_a = 1'b1;
        end
    endtask

    task automatic compare_q(input bit sel, input string tag);
        int         g[$];
        int         e[$];
        logic [4:0] ld;
        logic       lf;
        logic [7:0] o;
        if (sel) begin
            g = got_b; e = exp_b; ld = last_b; lf = ferr_b; o = out_b;
            got_b.delete(); exp_b.delete();
        end else begin
            g = got_a; e = exp_a; ld = last_a; lf = ferr_a; o = out_a;
            got_a.delete(); exp_a.delete();
        end
        check_eq({tag, "_count"}, g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++)
            check_eq({tag, "_data"}, g[i], e[i]);
        check_eq({tag, "_dout"}, {27'd0, o[4:0]}, {27'd0, ld});
        check_eq({tag, "_ferr"}, {31'd0, o[6]}, {31'd0, lf});
        check_eq({tag, "_busy"}, {31'd0, o[7]}, 32'd0);
    endtask

    initial begin
        int nb;
        logic bad;
        for (int y = 0; y < 32; y++) f_tab[g_tab[y]] = y;

        wait_cyc(3);
        check_eq("reset_out_a", {24'd0, out_a}, 32'd0);
        check_eq("reset_out_b", {24'd0, out_b}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Back-to-back decode with no idle gap.
        frame(1'b0, 5'h04, 1'b1);
        frame(1'b0, 5'h0F, 1'b1);
        frame(1'b0, 5'h1D, 1'b1);
        wait_cyc(6);
        check_eq("decode_pulses", cyc_a.size(), 32'd3);
        if (cyc_a.size() == 3) begin
            check_eq("decode_gap1", cyc_a[1] - cyc_a[0], 32'd7);
            check_eq("decode_gap2", cyc_a[2] - cyc_a[1], 32'd7);
        end
        check_eq("decode_last", {27'd0, out_a[4:0]}, 32'h1F);
        compare_q(1'b0, "decode");

        for (int x = 0; x < 32; x++) frame(1'b0, 5'(f_tab[x]), 1'b1);
        wait_cyc(6);
        compare_q(1'b0, "exhaustive");

        byp_a = 1'b1;
        frame(1'b0, 5'h1A, 1'b1);
        wait_cyc(4);
        check_eq("bypass_raw", {27'd0, out_a[4:0]}, 32'h1A);
        compare_q(1'b0, "bypass_on");
        byp_a = 1'b0;
        frame(1'b0, 5'h1A, 1'b1);
        wait_cyc(4);
        check_eq("bypass_off", {27'd0, out_a[4:0]}, 32'h10);
        compare_q(1'b0, "bypass_off");

        // Bad stop bit followed by a held break.
        frame(1'b0, 5'h04, 1'b0);
        wait_cyc(20);
        check_eq("ferr_set", {31'd0, out_a[6]}, 32'd1);
        check_eq("ferr_busy", {31'd0, out_a[7]}, 32'd1);
        check_eq("ferr_dout", {27'd0, out_a[4:0]}, {27'd0, last_a});
        check_eq("ferr_no_valid", got_a.size(), 32'd0);
        drive(1'b0, 1'b1);
        wait_cyc(4);
        check_eq("ferr_idle_busy", {31'd0, out_a[7]}, 32'd0);
        frame(1'b0, 5'h0B, 1'b1);
        wait_cyc(4);
        check_eq("ferr_recover", {27'd0, out_a[4:0]}, 32'h04);
        compare_q(1'b0, "ferr_recover");

        for (int i = 0; i < 60; i++) begin
            byp_a = 1'($urandom_range(0, 1));
            bad   = ($urandom_range(0, 5) == 0);
            frame(1'b0, 5'($urandom), ~bad);
            if (bad) begin
                wait_cyc($urandom_range(0, 4));
                drive(1'b0, 1'b1);
                wait_cyc(2);
            end
            wait_cyc(3 + $urandom_range(0, 2));
        end
        wait_cyc(4);
        compare_q(1'b0, "random");

        // Slow instance: prime data_out, then a one-cycle start glitch.
        frame(1'b1, 5'h05, 1'b1);
        wait_cyc(8);
        compare_q(1'b1, "b_prime");
        drive(1'b1, 1'b0);
        wait_cyc(1);
        drive(1'b1, 1'b1);
        nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_b[7]) nb++;
        end
        check_eq("glitch_busy_len", {31'd0, (nb >= 1 && nb <= 2)}, 32'd1);
        compare_q(1'b1, "glitch");
        frame(1'b1, 5'h1F, 1'b1);
        wait_cyc(12);
        check_eq("slow_decode", {27'd0, out_b[4:0]}, 32'h08);
        compare_q(1'b1, "slow_frame");

        // Reset in the middle of a frame, after data bit 2.
        send(1'b1, 5'h15, 1'b1, 4);
        wait_cyc(1);
        check_eq("midframe_busy", {31'd0, out_b[7]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_b", {24'd0, out_b}, 32'd0);
        check_eq("async_rst_a", {24'd0, out_a}, 32'd0);
        last_a = 5'd0; last_b = 5'd0; ferr_a = 1'b0; ferr_b = 1'b0;
        drive(1'b1, 1'b1);
        @(negedge clk);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(3);
        frame(1'b1, 5'h05, 1'b1);
        wait_cyc(12);
        check_eq("post_reset_dout", {27'd0, out_b[4:0]}, 32'h18);
        compare_q(1'b1, "post_reset_b");
        compare_q(1'b0, "post_reset_a");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
